// File: rtl/qam16_sym_sched_if.sv
// Handshake and mapper-side signal bundle for the QAM16 symbol scheduler.
// The master side is the byte source and controller; the slave side is the scheduler.
interface qam16_sym_sched_if;
  logic       tx_en;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] din;
  logic       sym_stb;
  logic       map_rst;
  logic       busy;
  logic       underrun;

  modport master (
    output tx_en, s_data, s_valid,
    input  s_ready, din, sym_stb, map_rst, busy, underrun
  );

  modport slave (
    input  tx_en, s_data, s_valid,
    output s_ready, din, sym_stb, map_rst, busy, underrun
  );
endinterface

// File: rtl/qam16_sym_sched.sv
// Frames payload bytes into preamble/payload/flush nibble symbols for the QAM16 mapper,
// presenting one symbol on din every SYM_DIV clocks and resetting the mapper per frame.
module qam16_sym_sched #(
  parameter int         SYM_DIV      = 8,
  parameter int         PREAMBLE_LEN = 4,
  parameter logic [3:0] PREAMBLE_NIB = 4'h0,
  parameter int         FRAME_LEN    = 16,
  parameter int         FLUSH_LEN    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  qam16_sym_sched_if.slave   bus
);

  localparam int SYM_W  = $clog2(SYM_DIV);
  localparam int PRE_W  = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam int BYTE_W = (FRAME_LEN > 1)    ? $clog2(FRAME_LEN)    : 1;
  localparam int FL_W   = (FLUSH_LEN > 1)    ? $clog2(FLUSH_LEN)    : 1;

  localparam logic [SYM_W-1:0]  SYM_LAST   = SYM_W'(SYM_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PREAMBLE_LEN - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(FRAME_LEN - 1);
  localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA, FLUSH} state_t;
  // What the current DATA symbol on din is: high nibble, low nibble, or an underrun pad.
  typedef enum logic [1:0] {PH_HI, PH_LO, PH_PAD} phase_t;

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [SYM_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [3:0]          lo_nib_q, lo_nib_d;
  logic [3:0]          din_q, din_d;
  logic                stb_q, stb_d;
  logic                under_q, under_d;
  logic                busy_q, busy_d;

  logic                boundary;
  logic                ready_c;
  logic                enter_pre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= PH_HI;
      sym_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      flush_cnt_q <= '0;
      lo_nib_q    <= '0;
      din_q       <= '0;
      stb_q       <= 1'b0;
      under_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sym_cnt_q   <= sym_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lo_nib_q    <= lo_nib_d;
      din_q       <= din_d;
      stb_q       <= stb_d;
      under_q     <= under_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    sym_cnt_d   = sym_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    flush_cnt_d = flush_cnt_q;
    lo_nib_d    = lo_nib_q;
    din_d       = din_q;
    stb_d       = 1'b0;
    under_d     = 1'b0;
    ready_c     = 1'b0;
    enter_pre   = 1'b0;

    if (state_q == IDLE) begin
      boundary = bus.tx_en;
    end else begin
      boundary  = (sym_cnt_q == SYM_LAST);
      sym_cnt_d = boundary ? '0 : sym_cnt_q + 1'b1;
    end

    if (boundary) begin
      unique case (state_q)
        IDLE: enter_pre = 1'b1;
        PRE: begin
          if (pre_cnt_q == PRE_LAST) begin
            state_d = DATA;
            ready_c = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
            din_d     = PREAMBLE_NIB;
            stb_d     = 1'b1;
          end
        end
        DATA: begin
          case (phase_q)
            PH_HI: begin
              din_d   = lo_nib_q;
              phase_d = PH_LO;
              stb_d   = 1'b1;
            end
            PH_LO: begin
              if (byte_cnt_q == BYTE_LAST) begin
                state_d     = FLUSH;
                flush_cnt_d = '0;
                din_d       = 4'h0;
                stb_d       = 1'b1;
              end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                ready_c    = 1'b1;
              end
            end
            PH_PAD:  ready_c = 1'b1;
            default: ;
          endcase
        end
        FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            if (bus.tx_en) begin
              enter_pre = 1'b1;
            end else begin
              state_d = IDLE;
              din_d   = 4'h0;
            end
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
            din_d       = 4'h0;
            stb_d       = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A missed byte sends a zero pad and leaves the byte index where it was.
    if (ready_c) begin
      stb_d = 1'b1;
      if (bus.s_valid) begin
        din_d    = bus.s_data[7:4];
        lo_nib_d = bus.s_data[3:0];
        phase_d  = PH_HI;
      end else begin
        din_d   = 4'h0;
        phase_d = PH_PAD;
        under_d = 1'b1;
      end
    end

    if (enter_pre) begin
      state_d    = PRE;
      sym_cnt_d  = '0;
      pre_cnt_d  = '0;
      byte_cnt_d = '0;
      phase_d    = PH_HI;
      din_d      = PREAMBLE_NIB;
      stb_d      = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.s_ready  = ready_c & rst_n;
  assign bus.map_rst  = enter_pre & rst_n;
  assign bus.din      = din_q;
  assign bus.sym_stb  = stb_q;
  assign bus.underrun = under_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_qam16_sym_sched.sv
// Directed self-checking bench for qam16_sym_sched: one instance at SYM_DIV=8 and
// one at SYM_DIV=2 with a single preamble symbol, both with two-byte frames.
module tb_qam16_sym_sched;

  logic clk;
  logic rst_n;

  qam16_sym_sched_if a ();
  qam16_sym_sched_if b ();

  qam16_sym_sched #(
    .SYM_DIV(8), .PREAMBLE_LEN(4), .PREAMBLE_NIB(4'h0), .FRAME_LEN(2), .FLUSH_LEN(2)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );

  qam16_sym_sched #(
    .SYM_DIV(2), .PREAMBLE_LEN(1), .PREAMBLE_NIB(4'h0), .FRAME_LEN(2), .FLUSH_LEN(2)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] byteTab [8] = '{8'hA5, 8'h3C, 8'h96, 8'hE1, 8'h7B, 8'h42, 8'h18, 8'hD0};

  logic [3:0] stbQ [$];
  int   ptr, cyc, lastStb, busyFallCyc;
  int   readyCnt, mapRstCnt, underCnt, underBad, gapBad, dinBad, busyLow;
  int   missLeft;
  logic acceptPend, prevBusy, txReq;
  logic [3:0] prevDin;

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [127:0] packSeq(input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = r << 4;
      r[3:0] = (i < stbQ.size()) ? stbQ[i] : 4'hF;
    end
    return r;
  endfunction

  task automatic clearMon();
    stbQ.delete();
    ptr = 0; cyc = 0; lastStb = -1; busyFallCyc = -1;
    readyCnt = 0; mapRstCnt = 0; underCnt = 0; underBad = 0;
    gapBad = 0; dinBad = 0; busyLow = 0; missLeft = 0;
    acceptPend = 1'b0; prevBusy = a.busy; prevDin = a.din;
  endtask

  // One cycle on instance A: drive inputs after the falling edge, then observe.
  task automatic applyStimulus();
    @(negedge clk);
    if (acceptPend) ptr++;
    a.tx_en  = txReq;
    a.s_data = byteTab[ptr];
    #1;
    if (a.s_ready && missLeft > 0) begin
      a.s_valid = 1'b0;
      missLeft--;
    end else begin
      a.s_valid = 1'b1;
    end
    #1;
    cyc++;
    acceptPend = a.s_ready && a.s_valid;
    if (a.s_ready) readyCnt++;
    if (a.map_rst) mapRstCnt++;
    if (a.underrun) begin
      underCnt++;
      if (!a.sym_stb) underBad++;
    end
    if (a.sym_stb) begin
      stbQ.push_back(a.din);
      if (lastStb >= 0 && cyc - lastStb != 8) gapBad++;
      lastStb = cyc;
    end else if (a.din != prevDin) begin
      dinBad++;
    end
    if (!a.busy) busyLow++;
    if (prevBusy && !a.busy) busyFallCyc = cyc;
    prevBusy = a.busy;
    prevDin  = a.din;
  endtask

  task automatic waitStbCount(input string tag, input int k);
    int n;
    n = 0;
    while (stbQ.size() < k && n < 600) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_stbReached"}, 128'(n < 600), 128'd1);
  endtask

  task automatic runUntilIdle(input string tag);
    int n;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!(stbQ.size() > 0 && !a.busy) && n < 600);
    checkOutput({tag, "_idleReached"}, 128'(n < 600), 128'd1);
  endtask

  int   bCyc, bFirstStb, bFirstReady, bReadyCnt, bGapBad, bLastStb, bPtr, bN;
  logic bAcc, bStarted;

  initial begin
    rst_n = 1'b0;
    txReq = 1'b0;
    a.tx_en = 1'b1; a.s_valid = 1'b1; a.s_data = 8'hA5;
    b.tx_en = 1'b0; b.s_valid = 1'b1; b.s_data = 8'hA5;
    #12;
    checkOutput("rst_outputsA", {a.din, a.sym_stb, a.map_rst, a.busy, a.underrun, a.s_ready}, '0);
    a.tx_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clearMon();

    // Plain frame: preamble, two bytes, flush.
    txReq = 1'b1;
    waitStbCount("t1", 1);
    checkOutput("t1_mapRstBeforeStb", 128'(mapRstCnt), 128'd1);
    checkOutput("t1_busyLowOnlyIdle", 128'(busyLow), 128'd1);
    txReq = 1'b0;
    runUntilIdle("t1");
    checkOutput("t1_seq", packSeq(10), 128'h0000A53C00);
    checkOutput("t1_len", 128'(stbQ.size()), 128'd10);
    checkOutput("t1_ready", 128'(readyCnt), 128'd2);
    checkOutput("t1_under", 128'(underCnt), 128'd0);
    checkOutput("t1_gap", 128'(gapBad), 128'd0);
    checkOutput("t1_hold", 128'(dinBad), 128'd0);
    checkOutput("t1_busyFall", 128'(busyFallCyc - lastStb), 128'd8);

    // First byte request misses: one pad symbol with an underrun pulse.
    clearMon();
    missLeft = 1;
    txReq = 1'b1;
    waitStbCount("t2", 1);
    txReq = 1'b0;
    runUntilIdle("t2");
    checkOutput("t2_seq", packSeq(11), 128'h00000A53C00);
    checkOutput("t2_len", 128'(stbQ.size()), 128'd11);
    checkOutput("t2_under", 128'(underCnt), 128'd1);
    checkOutput("t2_underInStb", 128'(underBad), 128'd0);
    checkOutput("t2_ready", 128'(readyCnt), 128'd3);
    checkOutput("t2_gap", 128'(gapBad), 128'd0);

    // Continuous tx_en: back-to-back frames, no idle cycle.
    clearMon();
    txReq = 1'b1;
    waitStbCount("t3", 24);
    checkOutput("t3_seq", packSeq(24), 128'h0000A53C00000096E1000000);
    checkOutput("t3_mapRst", 128'(mapRstCnt), 128'd3);
    checkOutput("t3_busyLow", 128'(busyLow), 128'd1);
    checkOutput("t3_gap", 128'(gapBad), 128'd0);
    txReq = 1'b0;
    runUntilIdle("t3");

    // tx_en dropped during the second payload symbol.
    clearMon();
    txReq = 1'b1;
    waitStbCount("t4", 6);
    txReq = 1'b0;
    runUntilIdle("t4");
    checkOutput("t4_seq", packSeq(10), 128'h0000A53C00);
    checkOutput("t4_len", 128'(stbQ.size()), 128'd10);
    checkOutput("t4_busyFall", 128'(busyFallCyc - lastStb), 128'd8);

    // Sub-cycle tx_en glitch in IDLE is never sampled.
    clearMon();
    @(negedge clk);
    a.tx_en = 1'b1;
    #1;
    a.tx_en = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("glitch_noStb", 128'(stbQ.size()), 128'd0);
    checkOutput("glitch_busyLow", 128'(busyLow), 128'd20);

    // Reset asserted mid-DATA for one cycle.
    clearMon();
    txReq = 1'b1;
    waitStbCount("t5", 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rstOutputs", {a.din, a.sym_stb, a.map_rst, a.busy, a.underrun, a.s_ready}, '0);
    @(negedge clk);
    a.tx_en = 1'b0;
    txReq = 1'b0;
    rst_n = 1'b1;
    #1;
    checkOutput("t5_idleAfterRst", 128'(a.busy), 128'd0);
    clearMon();
    txReq = 1'b1;
    waitStbCount("t5", 1);
    checkOutput("t5_mapRst", 128'(mapRstCnt), 128'd1);
    txReq = 1'b0;
    runUntilIdle("t5");
    checkOutput("t5_seq", packSeq(10), 128'h0000A53C00);

    // Instance B: SYM_DIV=2, single preamble symbol.
    bCyc = 0; bFirstStb = -1; bFirstReady = -1; bReadyCnt = 0; bGapBad = 0;
    bLastStb = -1; bPtr = 0; bAcc = 1'b0; bStarted = 1'b0; bN = 0;
    stbQ.delete();
    do begin
      @(negedge clk);
      if (bAcc) bPtr++;
      b.tx_en  = (bCyc == 0);
      b.s_data = byteTab[bPtr];
      b.s_valid = 1'b1;
      #1;
      bCyc++;
      bAcc = b.s_ready && b.s_valid;
      if (b.s_ready) begin
        bReadyCnt++;
        if (bFirstReady < 0) bFirstReady = bCyc;
      end
      if (b.sym_stb) begin
        stbQ.push_back(b.din);
        if (bFirstStb < 0) bFirstStb = bCyc;
        if (bLastStb >= 0 && bCyc - bLastStb != 2) bGapBad++;
        bLastStb = bCyc;
      end
      if (b.busy) bStarted = 1'b1;
      bN++;
    end while (!(bStarted && !b.busy) && bN < 200);
    checkOutput("t6_idleReached", 128'(bN < 200), 128'd1);
    checkOutput("t6_seq", packSeq(7), 128'h0A53C00);
    checkOutput("t6_len", 128'(stbQ.size()), 128'd7);
    checkOutput("t6_gap", 128'(bGapBad), 128'd0);
    checkOutput("t6_ready", 128'(bReadyCnt), 128'd2);
    checkOutput("t6_readyOnPreBnd", 128'(bFirstReady - bFirstStb), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
